// File: rtl/sqrt_mon_pkg.sv
// Shared types and saturation-limit helpers for the square-root error monitor.
package sqrt_mon_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      UPDATE = 2'd2
   } state_e;

   function automatic logic [63:0] umax_f(input int unsigned w);
      umax_f = (64'd1 << w) - 64'd1;
   endfunction

   function automatic logic signed [63:0] smax_f(input int unsigned w);
      smax_f = $signed((64'd1 << (w - 32'd1)) - 64'd1);
   endfunction

   function automatic logic signed [63:0] smin_f(input int unsigned w);
      smin_f = -$signed(64'd1 << (w - 32'd1));
   endfunction

endpackage

// File: rtl/sqrt_error_monitor_if.sv
// Sample handshake between a producer (master) and the error monitor (slave).
interface sqrt_error_monitor_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = IN_W / 2
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_r;
   logic [OUT_W-1:0] in_q;

   modport master (output in_valid, output in_r, output in_q, input in_ready);
   modport slave  (input in_valid, input in_r, input in_q, output in_ready);
endinterface

// File: rtl/sqrt_error_monitor_isqrt_iter.sv
// Restoring integer square root producing one root bit per cycle after start.
module isqrt_iter #(
   parameter int IN_W  = 16,
   parameter int OUT_W = IN_W / 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IN_W-1:0]  radicand,
   output logic             done,
   output logic [OUT_W-1:0] root
);
   localparam int REM_W  = OUT_W + 3;
   localparam int ITER_W = $clog2(OUT_W + 1);

   logic [IN_W-1:0]   rad_q, rad_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic [OUT_W-1:0]  root_q, root_d;
   logic [ITER_W-1:0] cnt_q, cnt_d;
   logic [REM_W-1:0]  shifted_s, trial_s;

   // One restoring step: bring down two radicand bits and try root*4+1.
   always_comb begin
      shifted_s = {rem_q[REM_W-3:0], rad_q[IN_W-1 -: 2]};
      trial_s   = {1'b0, root_q, 2'b01};
      rad_d     = rad_q;
      rem_d     = rem_q;
      root_d    = root_q;
      cnt_d     = cnt_q;
      if (start) begin
         rad_d  = radicand;
         rem_d  = '0;
         root_d = '0;
         cnt_d  = ITER_W'(OUT_W);
      end else if (cnt_q != '0) begin
         rad_d = {rad_q[IN_W-3:0], 2'b00};
         cnt_d = cnt_q - ITER_W'(1);
         if (shifted_s >= trial_s) begin
            rem_d  = shifted_s - trial_s;
            root_d = {root_q[OUT_W-2:0], 1'b1};
         end else begin
            rem_d  = shifted_s;
            root_d = {root_q[OUT_W-2:0], 1'b0};
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Iteration state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rad_q  <= '0;
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= '0;
      end else begin
         rad_q  <= rad_d;
         rem_q  <= rem_d;
         root_q <= root_d;
         cnt_q  <= cnt_d;
      end
   end

   // High during the cycle that resolves the last root bit.
   assign done = (cnt_q == ITER_W'(1));
   assign root = root_q;
endmodule

// File: rtl/sqrt_error_monitor.sv
// Measures |Q - floor(sqrt(R))| statistics; define SQRT_MON_BIAS_EN to add signed bias_sum.
module sqrt_error_monitor
   import sqrt_mon_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int CNT_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   sqrt_error_monitor_if.slave in_if,
   output logic                upd_valid,
   output logic [CNT_W-1:0]    sample_cnt,
   output logic [CNT_W-1:0]    err_cnt,
   output logic [CNT_W-1:0]    ed_sum,
   output logic [IN_W/2-1:0]   ed_max
`ifdef SQRT_MON_BIAS_EN
   ,
   output logic signed [CNT_W-1:0] bias_sum
`endif
);
   localparam int OUT_W = IN_W / 2;
   localparam int SUM_W = ((CNT_W > OUT_W + 1) ? CNT_W : OUT_W + 1) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(umax_f(CNT_W));

   state_e           state_q, state_d;
   logic [OUT_W-1:0] q_q, q_d;
   logic             start_s, done_s, iter_rst_s;
   logic [OUT_W-1:0] root_s;
   logic [OUT_W:0]   err_s;
   logic [SUM_W-1:0] sum_wide_s;
   logic             upd_valid_q, upd_valid_d;
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, err_cnt_q, err_cnt_d, ed_sum_q, ed_sum_d;
   logic [OUT_W-1:0] ed_max_q, ed_max_d;

   assign iter_rst_s = rst | clear;

   isqrt_iter #(.IN_W(IN_W), .OUT_W(OUT_W)) u_isqrt (
      .clk      (clk),
      .rst      (iter_rst_s),
      .start    (start_s),
      .radicand (in_if.in_r),
      .done     (done_s),
      .root     (root_s)
   );

   // Sequencing: accept in IDLE, iterate in CALC, absorb in UPDATE.
   always_comb begin
      state_d = state_q;
      start_s = 1'b0;
      q_d     = q_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_if.in_valid) begin
                  start_s = 1'b1;
                  q_d     = in_if.in_q;
                  state_d = CALC;
               end else begin
                  state_d = IDLE;
               end
            end
            CALC: begin
               if (done_s) state_d = UPDATE;
               else        state_d = CALC;
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Error magnitude and saturating statistics update.
   always_comb begin
      if ({1'b0, q_q} >= {1'b0, root_s}) err_s = {1'b0, q_q} - {1'b0, root_s};
      else                               err_s = {1'b0, root_s} - {1'b0, q_q};
      sum_wide_s   = SUM_W'(ed_sum_q) + SUM_W'(err_s);
      upd_valid_d  = 1'b0;
      sample_cnt_d = sample_cnt_q;
      err_cnt_d    = err_cnt_q;
      ed_sum_d     = ed_sum_q;
      ed_max_d     = ed_max_q;
      if (clear) begin
         sample_cnt_d = '0;
         err_cnt_d    = '0;
         ed_sum_d     = '0;
         ed_max_d     = '0;
      end else if (state_q == UPDATE) begin
         upd_valid_d = 1'b1;
         if (sample_cnt_q != CNT_MAX) sample_cnt_d = sample_cnt_q + CNT_W'(1);
         else                         sample_cnt_d = sample_cnt_q;
         if ((err_s != '0) && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_W'(1);
         else                                         err_cnt_d = err_cnt_q;
         if (sum_wide_s > SUM_W'(CNT_MAX)) ed_sum_d = CNT_MAX;
         else                              ed_sum_d = CNT_W'(sum_wide_s);
         if (err_s > {1'b0, ed_max_q}) ed_max_d = err_s[OUT_W-1:0];
         else                          ed_max_d = ed_max_q;
      end else begin
         upd_valid_d = 1'b0;
      end
   end

   // Control and statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         q_q          <= '0;
         upd_valid_q  <= 1'b0;
         sample_cnt_q <= '0;
         err_cnt_q    <= '0;
         ed_sum_q     <= '0;
         ed_max_q     <= '0;
      end else begin
         state_q      <= state_d;
         q_q          <= q_d;
         upd_valid_q  <= upd_valid_d;
         sample_cnt_q <= sample_cnt_d;
         err_cnt_q    <= err_cnt_d;
         ed_sum_q     <= ed_sum_d;
         ed_max_q     <= ed_max_d;
      end
   end

`ifdef SQRT_MON_BIAS_EN
   localparam logic signed [CNT_W-1:0] BIAS_MAX = CNT_W'(smax_f(CNT_W));
   localparam logic signed [CNT_W-1:0] BIAS_MIN = CNT_W'(smin_f(CNT_W));

   logic signed [CNT_W-1:0] bias_q, bias_d;
   logic signed [SUM_W-1:0] dev_s, bias_wide_s;

   // Signed bias accumulation clamped at both limits.
   always_comb begin
      dev_s       = SUM_W'($signed({1'b0, q_q})) - SUM_W'($signed({1'b0, root_s}));
      bias_wide_s = SUM_W'(bias_q) + dev_s;
      bias_d      = bias_q;
      if (clear) begin
         bias_d = '0;
      end else if (state_q == UPDATE) begin
         if (bias_wide_s > SUM_W'(BIAS_MAX))      bias_d = BIAS_MAX;
         else if (bias_wide_s < SUM_W'(BIAS_MIN)) bias_d = BIAS_MIN;
         else                                     bias_d = CNT_W'(bias_wide_s);
      end else begin
         bias_d = bias_q;
      end
   end

   // Bias register.
   always_ff @(posedge clk) begin
      if (rst) bias_q <= '0;
      else     bias_q <= bias_d;
   end

   assign bias_sum = bias_q;
`endif

   assign in_if.in_ready = (state_q == IDLE);
   assign upd_valid      = upd_valid_q;
   assign sample_cnt     = sample_cnt_q;
   assign err_cnt        = err_cnt_q;
   assign ed_sum         = ed_sum_q;
   assign ed_max         = ed_max_q;
endmodule

// File: doc/sqrt_error_monitor.md
SQRT_ERROR_MONITOR -- requirements
Module: sqrt_error_monitor

Interface
REQ-001 Parameter IN_W, default 16: radicand width; SHALL be even and within 4..32.
REQ-002 Parameter OUT_W, default IN_W/2: root width; SHALL be derived, not overridden.
REQ-003 Parameter CNT_W, default 32: width of every statistics counter.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 clear  input  1  synchronous statistics clear.
REQ-007 in_valid  input  1  sample present.
REQ-008 in_ready  output  1  block can accept a sample.
REQ-009 in_r  input  IN_W  radicand R.
REQ-010 in_q  input  OUT_W  approximate root Q under test.
REQ-011 upd_valid  output  1  one-cycle pulse after statistics absorb a sample.
REQ-012 sample_cnt  output  CNT_W  samples absorbed.
REQ-013 err_cnt  output  CNT_W  samples with Q != floor(sqrt(R)).
REQ-014 ed_sum  output  CNT_W  sum of |Q - floor(sqrt(R))|.
REQ-015 ed_max  output  OUT_W  maximum |Q - floor(sqrt(R))|.

Function
REQ-016 FSM states SHALL be IDLE, CALC, UPDATE.
REQ-017 IDLE: in_ready=1; on in_valid, latch in_r/in_q and go to CALC.
REQ-018 CALC: exactly OUT_W cycles, one root bit per cycle; then go to UPDATE.
REQ-019 UPDATE: one cycle; update all statistics, pulse upd_valid, return to IDLE.
REQ-020 Latency: accept edge to upd_valid SHALL be OUT_W+1 cycles; throughput 1 sample per OUT_W+2 cycles.
REQ-021 in_ready SHALL be 0 outside IDLE; in_valid there SHALL be ignored.
REQ-022 The reference root SHALL be the exact floor(sqrt(R)) for all 2^IN_W inputs.
REQ-023 The absolute error SHALL be computed at OUT_W+1 bits, unsigned, without wrap.
REQ-024 sample_cnt, err_cnt and ed_sum SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 ed_max SHALL update only on a strictly greater error.
REQ-026 clear SHALL zero all statistics and force IDLE, discarding any in-flight sample.
REQ-027 clear together with in_valid in IDLE: clear wins; the sample SHALL NOT be accepted.
REQ-028 R=0 SHALL give reference 0; R=2^IN_W-1 SHALL give reference 2^OUT_W-1.

Reset
REQ-029 rst SHALL force IDLE and clear all statistics and upd_valid to 0.
REQ-030 After rst, in_ready SHALL be 1; rst overrides clear and in_valid.

Configuration
REQ-031 Macro SQRT_MON_BIAS_EN defined: add output bias_sum, signed CNT_W.
REQ-032 bias_sum SHALL accumulate signed (Q - ref), saturating at both signed limits, and clear with the other statistics.
REQ-033 Macro absent: bias_sum port and logic SHALL NOT exist; all other behaviour is unchanged.

Structure
REQ-034 Package sqrt_mon_pkg SHALL hold the state typedef (IDLE/CALC/UPDATE) and the saturation-limit constant helpers.
REQ-035 Sub-module isqrt_iter SHALL hold the OUT_W-cycle restoring square root.
REQ-036 isqrt_iter interface: start, IN_W radicand, done, OUT_W root.

Verification
REQ-037 rst, then R=0, Q=0 -> after 9 cycles upd_valid; sample_cnt=1, err_cnt=0, ed_sum=0, ed_max=0.
REQ-038 R=15, Q=4, then R=99, Q=7 -> err_cnt=2, ed_sum=3, ed_max=2 (bias_sum=-1 if enabled).
REQ-039 R=65535, Q=255 -> err_cnt unchanged.
REQ-040 in_valid held during CALC -> in_ready=0; exactly one sample counted per IDLE acceptance.
REQ-041 clear asserted mid-CALC -> no upd_valid; all statistics 0; in_ready=1 next cycle.
REQ-042 CNT_W=4, 20 samples each with error 1 -> sample_cnt=15, err_cnt=15, ed_sum=15.
